// File: rtl/input_skew_unit.sv
// Diagonal skew stage feeding the systolic array rows: lane k is delayed k+1
// cycles, with stream/drain tracking that reports when the last element has left.
module input_skew_unit #(
    parameter int unsigned LANES  = 12,
    parameter int unsigned LANE_W = 8,
    parameter int unsigned CNT_W  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES*LANE_W-1:0]   i_vec,
    input  logic                      i_vec_valid,
    input  logic                      i_flush,
    output logic [LANES*LANE_W-1:0]   o_lane_data,
    output logic [LANES-1:0]          o_lane_valid,
    output logic                      o_busy,
    output logic                      o_drain_done,
    output logic [CNT_W-1:0]          o_vec_cnt
);

    // Triangular shift storage: lane k owns stages [k*(k+1)/2 +: k+1].
    localparam int unsigned NSTG   = LANES * (LANES + 1) / 2;
    localparam int unsigned DCNT_W = (LANES > 2) ? $clog2(LANES) : 1;
    // Counter value one short of LANES-1: the exit happens on the cycle it would reach LANES-1.
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(LANES - 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    logic [LANE_W-1:0] stg_data_q [NSTG];
    logic [LANE_W-1:0] stg_data_d [NSTG];
    logic [NSTG-1:0]   stg_vld_q;
    logic [NSTG-1:0]   stg_vld_d;

    state_t            state_q, state_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;

    always_comb begin
        for (int unsigned s = 0; s < NSTG; s++) begin
            stg_data_d[s] = '0;
        end
        stg_vld_d = '0;
        if (!i_flush) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                for (int unsigned j = 0; j <= k; j++) begin
                    if (j == 0) begin
                        stg_data_d[k*(k+1)/2] = i_vec_valid ? i_vec[k*LANE_W +: LANE_W] : '0;
                        stg_vld_d[k*(k+1)/2]  = i_vec_valid;
                    end else begin
                        stg_data_d[k*(k+1)/2 + j] = stg_data_q[k*(k+1)/2 + j - 1];
                        stg_vld_d[k*(k+1)/2 + j]  = stg_vld_q[k*(k+1)/2 + j - 1];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                stg_data_q[s] <= '0;
            end
            stg_vld_q <= '0;
        end else begin
            for (int unsigned s = 0; s < NSTG; s++) begin
                stg_data_q[s] <= stg_data_d[s];
            end
            stg_vld_q <= stg_vld_d;
        end
    end

    always_comb begin
        o_lane_data  = '0;
        o_lane_valid = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            o_lane_data[k*LANE_W +: LANE_W] = stg_data_q[k*(k+1)/2 + k];
            o_lane_valid[k]                 = stg_vld_q[k*(k+1)/2 + k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vcnt_q  <= vcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        if (i_flush) begin
            state_d = IDLE;
            dcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_vec_valid) begin
                        state_d = STREAM;
                    end
                end
                STREAM: begin
                    if (!i_vec_valid) begin
                        state_d = DRAIN;
                        dcnt_d  = '0;
                    end
                end
                DRAIN: begin
                    if (i_vec_valid) begin
                        state_d = STREAM;
                        dcnt_d  = '0;
                    end else if (dcnt_q == DRAIN_LAST) begin
                        state_d = IDLE;
                        dcnt_d  = '0;
                    end else begin
                        dcnt_d = dcnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    dcnt_d  = '0;
                end
            endcase
        end
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        done_d = (state_q == DRAIN) && (state_d == IDLE) && !i_flush;
        if (i_flush) begin
            vcnt_d = '0;
        end else if (i_vec_valid) begin
            vcnt_d = vcnt_q + 1'b1;
        end else begin
            vcnt_d = vcnt_q;
        end
    end

    assign o_busy       = busy_q;
    assign o_drain_done = done_q;
    assign o_vec_cnt    = vcnt_q;

endmodule

// File: tb/tb_input_skew_unit.sv
// Bench for input_skew_unit: directed scenarios plus random traffic, all compared
// against a history-based model of the skew, busy/drain-done and counter rules.
module tb_input_skew_unit;

    localparam int LANES  = 12;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 8;
    localparam int VW     = LANES * LANE_W;
    localparam int OW     = VW + LANES + 2 + CNT_W;

    logic              clk = 1'b0;
    logic              rst;
    logic [VW-1:0]     i_vec;
    logic              i_vec_valid;
    logic              i_flush;
    logic [VW-1:0]     o_lane_data;
    logic [LANES-1:0]  o_lane_valid;
    logic              o_busy;
    logic              o_drain_done;
    logic [CNT_W-1:0]  o_vec_cnt;
    logic [OW-1:0]     obs;
    logic [OW-1:0]     exp_v;

    int checks = 0;
    int errors = 0;
    int e   = 0;
    int clr = 0;
    logic [VW-1:0] hv [0:8191];
    bit            hval [0:8191];

    input_skew_unit #(.LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_vec        (i_vec),
        .i_vec_valid  (i_vec_valid),
        .i_flush      (i_flush),
        .o_lane_data  (o_lane_data),
        .o_lane_valid (o_lane_valid),
        .o_busy       (o_busy),
        .o_drain_done (o_drain_done),
        .o_vec_cnt    (o_vec_cnt)
    );

    always #5 clk = ~clk;

    assign obs = {o_lane_data, o_lane_valid, o_busy, o_drain_done, o_vec_cnt};

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom};
    endfunction

    // Drive one cycle, record what the edge accepted, then settle 1ns past the edge.
    task automatic drive(input bit v, input logic [VW-1:0] d, input bit f);
        i_vec_valid = v;
        i_vec       = d;
        i_flush     = f;
        @(posedge clk);
        e++;
        hval[e] = v && !f && !rst;
        hv[e]   = d;
        if (f || rst) clr = e;
        #1;
    endtask

    // Expected outputs after edge e: lane k shows what edge e-k accepted;
    // busy while the newest accepted vector is < LANES edges old; done exactly LANES edges after it.
    function automatic logic [OW-1:0] model();
        logic [VW-1:0]    d;
        logic [LANES-1:0] v;
        logic [CNT_W-1:0] c;
        int               last;
        bit               found;
        d = '0; v = '0; c = '0; last = 0; found = 0;
        for (int k = 0; k < LANES; k++) begin
            if (e - k > clr && e - k >= 1 && hval[e-k]) begin
                d[k*LANE_W +: LANE_W] = hv[e-k][k*LANE_W +: LANE_W];
                v[k] = 1'b1;
            end
        end
        for (int s = e; s > clr && s >= 1; s--) begin
            if (hval[s]) begin
                c++;
                if (!found) begin
                    found = 1;
                    last  = s;
                end
            end
        end
        return {d, v, found && (e - last < LANES), found && (e - last == LANES), c};
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_t0 got=%h exp=0", obs);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, rand_vec(), 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL reset_hold e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_vector(input string tag);
        logic [VW-1:0] v;
        int e0, nd, de;
        nd = 0; de = -1;
        drive(0, '0, 1);
        for (int i = 0; i < 3; i++) drive(0, '0, 0);
        for (int k = 0; k < LANES; k++) v[k*LANE_W +: LANE_W] = 8'(k + 1);
        drive(1, v, 0);
        e0 = e;
        for (int i = 0; i < 16; i++) begin
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s_model e=%0d got=%h exp=%h", tag, e, obs, exp_v);
            end
            if (i < LANES) begin
                checks++;
                if (o_lane_data[i*LANE_W +: LANE_W] !== 8'(i + 1) || o_lane_valid !== (12'b1 << i)) begin
                    errors++;
                    $display("FAIL %s_lane%0d data=%h valid=%b exp_data=%h", tag, i,
                             o_lane_data[i*LANE_W +: LANE_W], o_lane_valid, 8'(i + 1));
                end
            end
            if (o_drain_done === 1'b1) begin
                nd++;
                de = e;
            end
            drive(0, rand_vec(), 0);
        end
        checks++;
        if (nd != 1 || de != e0 + LANES) begin
            errors++;
            $display("FAIL %s_done pulses=%0d at_edge=%0d exp 1 at %0d", tag, nd, de, e0 + LANES);
        end
        checks++;
        if (o_vec_cnt !== 8'd1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_cnt cnt=%0d busy=%b exp cnt=1 busy=0", tag, o_vec_cnt, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] vv [4];
        int e0, nd, de;
        nd = 0; de = -1;
        drive(0, '0, 1);
        for (int i = 0; i < 4; i++) begin
            vv[i] = rand_vec();
            drive(1, vv[i], 0);
        end
        e0 = e;
        checks++;
        if (o_lane_data[0 +: 8] !== vv[3][0 +: 8] || o_lane_data[8 +: 8] !== vv[2][8 +: 8] ||
            o_lane_data[16 +: 8] !== vv[1][16 +: 8] || o_lane_data[24 +: 8] !== vv[0][24 +: 8] ||
            o_lane_valid !== 12'h00F) begin
            errors++;
            $display("FAIL b2b_diag got=%h valid=%b exp=%h%h%h%h", o_lane_data[31:0], o_lane_valid,
                     vv[0][31:24], vv[1][23:16], vv[2][15:8], vv[3][7:0]);
        end
        for (int i = 0; i < 16; i++) begin
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b_model e=%0d got=%h exp=%h", e, obs, exp_v);
            end
            if (o_drain_done === 1'b1) begin
                nd++;
                de = e;
            end
            drive(0, '0, 0);
        end
        checks++;
        if (nd != 1 || de != e0 + LANES || o_vec_cnt !== 8'd4) begin
            errors++;
            $display("FAIL b2b_done pulses=%0d at=%0d cnt=%0d exp 1 at %0d cnt=4", nd, de, o_vec_cnt, e0 + LANES);
        end
    endtask

    task automatic test_idle_invalid();
        drive(0, '0, 1);
        for (int i = 0; i < 20; i++) begin
            drive(0, '1, 0);
            checks++;
            if (o_lane_data !== '0 || o_lane_valid !== '0 || o_busy !== 1'b0) begin
                errors++;
                $display("FAIL idle_gate data=%h valid=%b busy=%b exp all 0", o_lane_data, o_lane_valid, o_busy);
            end
        end
    endtask

    task automatic test_gap();
        bit pat [6] = '{1, 1, 0, 0, 0, 1};
        int elast, nd, de;
        nd = 0; de = -1;
        drive(0, '0, 1);
        for (int i = 0; i < 6; i++) begin
            drive(pat[i], rand_vec(), 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL gap_model e=%0d got=%h exp=%h", e, obs, exp_v);
            end
            if (o_drain_done === 1'b1) nd++;
        end
        elast = e;
        for (int i = 0; i < 16; i++) begin
            drive(0, rand_vec(), 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL gap_model e=%0d got=%h exp=%h", e, obs, exp_v);
            end
            if (o_drain_done === 1'b1) begin
                nd++;
                de = e;
            end
        end
        checks++;
        if (nd != 1 || de != elast + LANES) begin
            errors++;
            $display("FAIL gap_done pulses=%0d at=%0d exp 1 at %0d", nd, de, elast + LANES);
        end
    endtask

    task automatic test_flush();
        int nd;
        nd = 0;
        drive(0, '0, 1);
        for (int i = 0; i < 5; i++) drive(1, rand_vec(), 0);
        drive(1, rand_vec(), 1);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL flush_clear got=%h exp=0", obs);
        end
        for (int i = 0; i < 16; i++) begin
            drive(0, '0, 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL flush_model e=%0d got=%h exp=%h", e, obs, exp_v);
            end
            if (o_drain_done === 1'b1) nd++;
        end
        checks++;
        if (nd != 0) begin
            errors++;
            $display("FAIL flush_done pulses=%0d exp 0", nd);
        end
    endtask

    task automatic test_async_reset();
        drive(0, '0, 1);
        drive(1, rand_vec(), 0);
        for (int i = 0; i < 5; i++) drive(0, '0, 0);
        #3;
        rst = 1'b1;
        clr = e;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL async_rst got=%h exp=0", obs);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, rand_vec(), 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL async_hold e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
        rst = 1'b0;
        test_single_vector("post_rst");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 9) < 6, rand_vec(), $urandom_range(0, 39) == 0);
            exp_v = model();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL rand_model e=%0d got=%h exp=%h", e, obs, exp_v);
            end
        end
    endtask

    initial begin
        rst         = 1'b1;
        i_vec       = '0;
        i_vec_valid = 1'b0;
        i_flush     = 1'b0;
        test_reset();
        test_single_vector("single");
        test_back_to_back();
        test_idle_invalid();
        test_gap();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
